// File: rtl/fetch_decode_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: PC, redirects from the
// Controller, stall/flush handling and combinational decode field slicing.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic [31:0] JumpRegAddr,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemData,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic [31:0] PCPlus4,
  output logic        Valid,
  output logic [5:0]  OPCode,
  output logic [5:0]  Function,
  output logic [4:0]  TargetReg,
  output logic [4:0]  Rs,
  output logic [4:0]  Rd,
  output logic [15:0] Imm,
  output logic [31:0] FetchCount
);

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_REDIRECT,
    ACT_FLUSH,
    ACT_FETCH
  } action_t;

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;
  logic [31:0] count_q;

  action_t     action;
  logic        redir;
  logic [31:0] seq_pc;
  logic [31:0] branch_off;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] target;

  assign seq_pc        = pc_q + 32'd4;
  assign branch_off    = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign branch_target = pc_plus4_q + branch_off;
  assign jump_target   = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};

  // Redirect requests only count for a real instruction sitting in IF/ID.
  assign redir = valid_q & (JumpReg | Jump | Branch);

  always_comb begin
    target = branch_target;
    if (JumpReg) begin
      target = JumpRegAddr;
    end else if (Jump) begin
      target = jump_target;
    end
  end

  always_comb begin
    action = ACT_FETCH;
    if (Stall) begin
      action = ACT_HOLD;
    end else if (redir) begin
      action = ACT_REDIRECT;
    end else if (Flush) begin
      action = ACT_FLUSH;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_WORD;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      unique case (action)
        ACT_HOLD: begin
          if (Flush) begin
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
          end
        end
        ACT_REDIRECT: begin
          pc_q    <= target;
          instr_q <= NOP_WORD;
          valid_q <= 1'b0;
        end
        ACT_FLUSH: begin
          pc_q    <= seq_pc;
          instr_q <= NOP_WORD;
          valid_q <= 1'b0;
        end
        ACT_FETCH: begin
          pc_q       <= seq_pc;
          instr_q    <= ImemData;
          pc_plus4_q <= seq_pc;
          valid_q    <= 1'b1;
          count_q    <= count_q + 32'd1;
        end
      endcase
    end
  end

  assign ImemAddr    = pc_q;
  assign PC          = pc_q;
  assign Instruction = instr_q;
  assign PCPlus4     = pc_plus4_q;
  assign Valid       = valid_q;
  assign FetchCount  = count_q;

  assign OPCode    = instr_q[31:26];
  assign Function  = instr_q[5:0];
  assign TargetReg = instr_q[20:16];
  assign Rs        = instr_q[25:21];
  assign Rd        = instr_q[15:11];
  assign Imm       = instr_q[15:0];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: directed scenarios plus randomized traffic
// checked against a rule-level reference model of the fetch stage.
module tb_fetch_decode_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branch;
  logic        jump;
  logic        jump_reg;
  logic [31:0] jump_reg_addr;

  logic [31:0] imem_addr, imem_data, pc, instr, pc_plus4, fetch_count;
  logic        valid;
  logic [5:0]  opcode, funct;
  logic [4:0]  rt, rs, rd;
  logic [15:0] imm;

  logic [31:0] w_addr, w_data, w_pc, w_instr, w_pp4, w_count;
  logic        w_valid;
  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rt, w_rs, w_rd;
  logic [15:0] w_imm;

  logic [31:0] mem [256];
  assign imem_data = mem[imem_addr[9:2]];
  assign w_data    = mem[w_addr[9:2]];

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
  logic        m_valid;

  fetch_decode_stage #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut (
    .Clk(clk), .Reset(reset), .Stall(stall), .Flush(flush), .Branch(branch),
    .Jump(jump), .JumpReg(jump_reg), .JumpRegAddr(jump_reg_addr),
    .ImemAddr(imem_addr), .ImemData(imem_data), .PC(pc), .Instruction(instr),
    .PCPlus4(pc_plus4), .Valid(valid), .OPCode(opcode), .Function(funct),
    .TargetReg(rt), .Rs(rs), .Rd(rd), .Imm(imm), .FetchCount(fetch_count)
  );

  fetch_decode_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_WORD(32'h0000_0000)) dut_wrap (
    .Clk(clk), .Reset(reset), .Stall(stall), .Flush(flush), .Branch(branch),
    .Jump(jump), .JumpReg(jump_reg), .JumpRegAddr(jump_reg_addr),
    .ImemAddr(w_addr), .ImemData(w_data), .PC(w_pc), .Instruction(w_instr),
    .PCPlus4(w_pp4), .Valid(w_valid), .OPCode(w_opcode), .Function(w_funct),
    .TargetReg(w_rt), .Rs(w_rs), .Rd(w_rd), .Imm(w_imm), .FetchCount(w_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge();
    logic [31:0] tgt;
    int          off;
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    end else if (stall) begin
      if (flush) begin
        m_instr = 32'h0; m_valid = 1'b0;
      end
    end else if (m_valid && (jump_reg || jump || branch)) begin
      if (jump_reg) tgt = jump_reg_addr;
      else if (jump) tgt = (m_pp4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
      else begin
        off = $signed(m_instr[15:0]);
        tgt = m_pp4 + 32'(off * 4);
      end
      m_pc = tgt; m_instr = 32'h0; m_valid = 1'b0;
    end else if (flush) begin
      m_pc = m_pc + 4; m_instr = 32'h0; m_valid = 1'b0;
    end else begin
      m_instr = mem[m_pc[9:2]];
      m_pp4 = m_pc + 4;
      m_pc = m_pc + 4;
      m_valid = 1'b1;
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    branch = 1'b0; jump = 1'b0; jump_reg = 1'b0; jump_reg_addr = 32'h0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
  endtask

  task automatic test_reset();
    idle();
    branch = 1'b1; jump_reg = 1'b1; jump_reg_addr = 32'h1234;
    reset = 1'b1;
    step();
    idle();
    checks++;
    if (pc !== 32'h0 || instr !== 32'h0 || pc_plus4 !== 32'h0 || valid !== 1'b0 || fetch_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got pc=%h instr=%h pp4=%h valid=%b cnt=%0d want all zero",
               pc, instr, pc_plus4, valid, fetch_count);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] words [3];
    fill_mem();
    for (int i = 0; i < 3; i++) begin
      words[i] = $urandom;
      mem[i] = words[i];
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (instr !== words[i] || pc_plus4 !== 32'(4 * (i + 1)) || valid !== 1'b1 || fetch_count !== 32'(i + 1)) begin
        errors++;
        $display("FAIL seq_fetch%0d got instr=%h pp4=%h valid=%b cnt=%0d want %h %h 1 %0d",
                 i, instr, pc_plus4, valid, fetch_count, words[i], 4 * (i + 1), i + 1);
      end
    end
  endtask

  task automatic test_branch();
    fill_mem();
    mem[2] = 32'h1000_0003;
    do_reset();
    repeat (3) step();
    branch = 1'b1;
    step();
    branch = 1'b0;
    checks++;
    if (pc !== 32'h18 || valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_redirect got pc=%h valid=%b want 00000018 0", pc, valid);
    end
    step();
    checks++;
    if (instr !== mem[6] || pc_plus4 !== 32'h1C || valid !== 1'b1 || fetch_count !== 32'd4) begin
      errors++;
      $display("FAIL branch_target got instr=%h pp4=%h valid=%b cnt=%0d want %h 0000001c 1 4",
               instr, pc_plus4, valid, fetch_count, mem[6]);
    end
    mem[2] = 32'h1000_FFFF;
    do_reset();
    repeat (3) step();
    branch = 1'b1;
    step();
    branch = 1'b0;
    checks++;
    if (pc !== 32'h8 || valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_negative got pc=%h valid=%b want 00000008 0", pc, valid);
    end
  endtask

  task automatic test_jump();
    fill_mem();
    mem[4] = 32'h0800_0010;
    do_reset();
    repeat (5) step();
    checks++;
    if (instr !== 32'h0800_0010 || pc_plus4 !== 32'h14 || opcode !== 6'h02 || imm !== 16'h0010) begin
      errors++;
      $display("FAIL jump_setup got instr=%h pp4=%h opc=%h imm=%h want 08000010 00000014 02 0010",
               instr, pc_plus4, opcode, imm);
    end
    jump = 1'b1; branch = 1'b1;
    step();
    idle();
    checks++;
    if (pc !== 32'h40 || valid !== 1'b0) begin
      errors++;
      $display("FAIL jump_redirect got pc=%h valid=%b want 00000040 0", pc, valid);
    end
    step();
    checks++;
    if (instr !== mem[16] || pc_plus4 !== 32'h44 || valid !== 1'b1) begin
      errors++;
      $display("FAIL jump_target got instr=%h pp4=%h valid=%b want %h 00000044 1",
               instr, pc_plus4, valid, mem[16]);
    end
  endtask

  task automatic test_jumpreg();
    fill_mem();
    do_reset();
    step();
    jump_reg = 1'b1; jump = 1'b1; jump_reg_addr = 32'h100;
    step();
    checks++;
    if (pc !== 32'h100 || valid !== 1'b0) begin
      errors++;
      $display("FAIL jr_redirect got pc=%h valid=%b want 00000100 0", pc, valid);
    end
    // IF/ID now holds a bubble, so the same request must be ignored
    step();
    checks++;
    if (pc !== 32'h104 || valid !== 1'b1 || instr !== mem[64] || fetch_count !== 32'd2) begin
      errors++;
      $display("FAIL jr_ignored_invalid got pc=%h valid=%b instr=%h cnt=%0d want 00000104 1 %h 2",
               pc, valid, instr, fetch_count, mem[64]);
    end
    jump = 1'b0; jump_reg_addr = 32'h0000_0203;
    step();
    idle();
    checks++;
    if (pc !== 32'h203 || imem_addr !== 32'h203) begin
      errors++;
      $display("FAIL jr_unaligned got pc=%h addr=%h want 00000203", pc, imem_addr);
    end
  endtask

  task automatic test_stall();
    fill_mem();
    mem[2] = 32'h1000_0003;
    do_reset();
    repeat (3) step();
    branch = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc !== 32'hC || instr !== 32'h1000_0003 || fetch_count !== 32'd3 || valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d got pc=%h instr=%h cnt=%0d valid=%b want 0000000c 10000003 3 1",
                 i, pc, instr, fetch_count, valid);
      end
    end
    stall = 1'b0;
    step();
    branch = 1'b0;
    checks++;
    if (pc !== 32'h18 || valid !== 1'b0 || fetch_count !== 32'd3) begin
      errors++;
      $display("FAIL stall_release got pc=%h valid=%b cnt=%0d want 00000018 0 3", pc, valid, fetch_count);
    end
    step();
    stall = 1'b1; flush = 1'b1;
    step();
    idle();
    checks++;
    if (valid !== 1'b0 || pc !== 32'h1C || fetch_count !== 32'd4 || instr !== 32'h0) begin
      errors++;
      $display("FAIL stall_flush got valid=%b pc=%h cnt=%0d instr=%h want 0 0000001c 4 00000000",
               valid, pc, fetch_count, instr);
    end
    flush = 1'b1;
    step();
    idle();
    checks++;
    if (valid !== 1'b0 || pc !== 32'h20 || fetch_count !== 32'd4) begin
      errors++;
      $display("FAIL flush_only got valid=%b pc=%h cnt=%0d want 0 00000020 4", valid, pc, fetch_count);
    end
  endtask

  task automatic test_wrap();
    fill_mem();
    do_reset();
    checks++;
    if (w_pc !== 32'hFFFF_FFFC || w_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_reset got pc=%h valid=%b want fffffffc 0", w_pc, w_valid);
    end
    step();
    checks++;
    if (w_instr !== mem[255] || w_pp4 !== 32'h0 || w_pc !== 32'h0) begin
      errors++;
      $display("FAIL wrap_first got instr=%h pp4=%h pc=%h want %h 00000000 00000000",
               w_instr, w_pp4, w_pc, mem[255]);
    end
    step();
    checks++;
    if (w_instr !== mem[0] || w_pp4 !== 32'h4 || w_count !== 32'd2) begin
      errors++;
      $display("FAIL wrap_second got instr=%h pp4=%h cnt=%0d want %h 00000004 2",
               w_instr, w_pp4, w_count, mem[0]);
    end
  endtask

  task automatic test_reset_mid_redirect();
    fill_mem();
    do_reset();
    repeat (2) step();
    branch = 1'b1; jump_reg = 1'b1; jump_reg_addr = 32'h80; reset = 1'b1;
    step();
    idle();
    checks++;
    if (pc !== 32'h0 || valid !== 1'b0 || fetch_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_redirect got pc=%h valid=%b cnt=%0d want 00000000 0 0",
               pc, valid, fetch_count);
    end
  endtask

  task automatic test_random();
    fill_mem();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset         = ($urandom_range(0, 59) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      flush         = ($urandom_range(0, 6) == 0);
      branch        = ($urandom_range(0, 5) == 0);
      jump          = ($urandom_range(0, 9) == 0);
      jump_reg      = ($urandom_range(0, 11) == 0);
      jump_reg_addr = $urandom;
      if ($urandom_range(0, 7) == 0) mem[$urandom_range(0, 255)] = $urandom;
      step();
      checks++;
      if (pc !== m_pc || imem_addr !== m_pc || instr !== m_instr || valid !== m_valid ||
          fetch_count !== m_cnt || (m_valid && pc_plus4 !== m_pp4)) begin
        errors++;
        $display("FAIL rand_state cyc%0d got pc=%h instr=%h pp4=%h valid=%b cnt=%0d want %h %h %h %b %0d",
                 c, pc, instr, pc_plus4, valid, fetch_count, m_pc, m_instr, m_pp4, m_valid, m_cnt);
      end
      checks++;
      if (opcode !== 6'(m_instr >> 26) || funct !== 6'(m_instr) || rt !== 5'(m_instr >> 16) ||
          rs !== 5'(m_instr >> 21) || rd !== 5'(m_instr >> 11) || imm !== 16'(m_instr)) begin
        errors++;
        $display("FAIL rand_fields cyc%0d got opc=%h fn=%h rt=%h rs=%h rd=%h imm=%h for instr %h",
                 c, opcode, funct, rt, rs, rd, imm, m_instr);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    fill_mem();
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_jumpreg();
    test_stall();
    test_wrap();
    test_reset_mid_redirect();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
